cnc_arbiter: RTL



---
 rtl/cnc_pkg.sv | 11 +
 rtl/cnc_arbiter_rr.sv | 31 +++
 rtl/cnc_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cnc_pkg.sv
// cnc_pkg: shared state encoding, CNC port geometry and operand byte helper.
package cnc_pkg;
    typedef enum logic [2:0] {IDLE, SEND, WAIT, COLLECT, RESP, FLUSH} state_t;
    localparam int CNC_IN_W      = 8;
    localparam int CNC_OUT_W     = 17;
    localparam int CNC_BEATS_IN  = 4;
    localparam int CNC_BEATS_OUT = 2;
    function automatic logic [CNC_IN_W-1:0] op_byte(input logic [31:0] d, input logic [1:0] b);
        return d[CNC_IN_W*(CNC_BEATS_IN-1-int'(b)) +: CNC_IN_W];
    endfunction
endpackage

// File: rtl/cnc_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or after ptr.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic [IDW-1:0]  nxt,
    output logic            any
);
    int j;
    always_comb begin
        grant = '0;
        idx   = '0;
        nxt   = ptr;
        any   = 1'b0;
        j     = 0;
        // scan farthest-first so the closest valid requester is written last
        for (int k = NREQ-1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (valid[j]) begin
                grant = NREQ'(1) << j;
                idx   = IDW'(j);
                nxt   = IDW'((j + 1) % NREQ);
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cnc_arbiter.sv
// cnc_arbiter: round-robin sharing of one CNC datapath; serialises operands, collects the
// two-beat result and recovers the datapath with a watchdog flush.
module cnc_arbiter
    import cnc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 cnc_rst_n,
    output logic                 cnc_in_valid,
    output logic [1:0]           cnc_mode,
    output logic [CNC_IN_W-1:0]  cnc_in,
    input  logic                 cnc_out_valid,
    input  logic [CNC_OUT_W-1:0] cnc_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [CNC_OUT_W-1:0] rsp_re,
    output logic [CNC_OUT_W-1:0] rsp_im,
    output logic                 rsp_err,
    output logic                 busy
);
    localparam int WDW = $clog2(TIMEOUT) + 1;

    state_t               state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       gid;
    logic [31:0]          data;
    logic [1:0]           beat;
    logic [WDW-1:0]       wdog;
    logic [CNC_OUT_W-1:0] re;
    logic [NREQ-1:0]      arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic [IDW-1:0]       arb_nxt;
    logic                 arb_any;
    logic                 issue;
    logic [31:0]          sel_data;
    logic [1:0]           sel_mode;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .grant(arb_grant),
        .idx  (arb_idx),
        .nxt  (arb_nxt),
        .any  (arb_any)
    );

    // Outputs are registered, so the grant is decided one cycle ahead of the IDLE cycle it shows in.
    assign issue    = (state == IDLE && req_ready == '0) || state == RESP || (state == FLUSH && rsp_valid);
    assign sel_data = req_data[32*gid +: 32];
    assign sel_mode = req_mode[2*gid +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gid          <= '0;
            data         <= '0;
            beat         <= '0;
            wdog         <= '0;
            re           <= '0;
            req_ready    <= '0;
            cnc_rst_n    <= 1'b0;
            cnc_in_valid <= 1'b0;
            cnc_mode     <= '0;
            cnc_in       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_re       <= '0;
            rsp_im       <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            req_ready <= issue ? arb_grant : '0;
            if (issue && arb_any) begin
                rr_ptr <= arb_nxt;
                gid    <= arb_idx;
            end
            cnc_rst_n <= 1'b1;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_ready != '0) begin
                    state        <= SEND;
                    busy         <= 1'b1;
                    data         <= sel_data;
                    beat         <= '0;
                    cnc_in_valid <= 1'b1;
                    cnc_mode     <= sel_mode;
                    cnc_in       <= op_byte(sel_data, 2'd0);
                end
                SEND: if (beat == 2'(CNC_BEATS_IN-1)) begin
                    state        <= WAIT;
                    wdog         <= '0;
                    cnc_in_valid <= 1'b0;
                    cnc_mode     <= '0;
                    cnc_in       <= '0;
                end else begin
                    beat   <= beat + 2'd1;
                    cnc_in <= op_byte(data, beat + 2'd1);
                end
                WAIT: if (cnc_out_valid) begin
                    re    <= cnc_out;
                    state <= COLLECT;
                end else if (wdog == WDW'(TIMEOUT-1)) begin
                    state     <= FLUSH;
                    cnc_rst_n <= 1'b0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                COLLECT: if (cnc_out_valid) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= gid;
                    rsp_re    <= re;
                    rsp_im    <= cnc_out;
                    rsp_err   <= 1'b0;
                end else begin
                    state     <= FLUSH;
                    cnc_rst_n <= 1'b0;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                FLUSH: if (!rsp_valid) begin
                    cnc_rst_n <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_id    <= gid;
                    rsp_re    <= '0;
                    rsp_im    <= '0;
                    rsp_err   <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
